// File: rtl/riscv_inst_pkg.sv
// Shared RV32I decode definitions: one-hot instruction ids, major opcodes and
// the decoded-field bundle passed from the decoder into the stage slots.
package riscv_inst_pkg;

  localparam logic [63:0] inst_UNKNOWN = 64'd1 << 0,  inst_ADD    = 64'd1 << 1,  inst_SUB    = 64'd1 << 2;
  localparam logic [63:0] inst_XOR     = 64'd1 << 3,  inst_OR     = 64'd1 << 4,  inst_AND    = 64'd1 << 5;
  localparam logic [63:0] inst_SLL     = 64'd1 << 6,  inst_SRL    = 64'd1 << 7,  inst_SRA    = 64'd1 << 8;
  localparam logic [63:0] inst_SLT     = 64'd1 << 9,  inst_SLTU   = 64'd1 << 10, inst_ADDI   = 64'd1 << 11;
  localparam logic [63:0] inst_XORI    = 64'd1 << 12, inst_ORI    = 64'd1 << 13, inst_ANDI   = 64'd1 << 14;
  localparam logic [63:0] inst_SLLI    = 64'd1 << 15, inst_SRLI   = 64'd1 << 16, inst_SRAI   = 64'd1 << 17;
  localparam logic [63:0] inst_SLTI    = 64'd1 << 18, inst_SLTIU  = 64'd1 << 19, inst_LB     = 64'd1 << 20;
  localparam logic [63:0] inst_LH      = 64'd1 << 21, inst_LW     = 64'd1 << 22, inst_LBU    = 64'd1 << 23;
  localparam logic [63:0] inst_LHU     = 64'd1 << 24, inst_SB     = 64'd1 << 25, inst_SH     = 64'd1 << 26;
  localparam logic [63:0] inst_SW      = 64'd1 << 27, inst_BEQ    = 64'd1 << 28, inst_BNE    = 64'd1 << 29;
  localparam logic [63:0] inst_BLT     = 64'd1 << 30, inst_BGE    = 64'd1 << 31, inst_BLTU   = 64'd1 << 32;
  localparam logic [63:0] inst_BGEU    = 64'd1 << 33, inst_JAL    = 64'd1 << 34, inst_JALR   = 64'd1 << 35;
  localparam logic [63:0] inst_LUI     = 64'd1 << 36, inst_AUIPC  = 64'd1 << 37, inst_ECALL  = 64'd1 << 38;
  localparam logic [63:0] inst_EBREAK  = 64'd1 << 39, inst_FENCE  = 64'd1 << 40, inst_FENCEI = 64'd1 << 41;
  localparam logic [63:0] inst_CSRRW   = 64'd1 << 42, inst_CSRRS  = 64'd1 << 43, inst_CSRRC  = 64'd1 << 44;
  localparam logic [63:0] inst_CSRRWI  = 64'd1 << 45, inst_CSRRSI = 64'd1 << 46, inst_CSRRCI = 64'd1 << 47;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic [63:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    dec_t        dec;
    logic [31:0] pc;
  } slot_t;

endpackage

// File: rtl/rv32i_inst_decoder.sv
// Combinational RV32I + Zicsr + Zifencei decoder: raw word to one-hot id,
// raw register/funct fields and the format-specific sign-extended immediate.
module rv32i_inst_decoder
  import riscv_inst_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;

  assign op      = instruction[6:0];
  assign f3      = instruction[14:12];
  assign f7      = instruction[31:25];
  assign imm_i   = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b   = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
  assign imm_u   = {instruction[31:12], 12'b0};
  assign imm_j   = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};
  assign imm_sh  = {27'b0, instruction[24:20]};
  assign imm_csr = {20'b0, instruction[31:20]};

  always_comb begin
    dec      = '0;
    dec.inst = inst_UNKNOWN;
    dec.rd   = instruction[11:7];
    dec.rs1  = instruction[19:15];
    dec.rs2  = instruction[24:20];
    dec.fun3 = f3;
    dec.fun7 = f7;
    case (op)
      OP: begin
        case ({f7, f3})
          {7'h00, 3'd0}: dec.inst = inst_ADD;
          {7'h20, 3'd0}: dec.inst = inst_SUB;
          {7'h00, 3'd1}: dec.inst = inst_SLL;
          {7'h00, 3'd2}: dec.inst = inst_SLT;
          {7'h00, 3'd3}: dec.inst = inst_SLTU;
          {7'h00, 3'd4}: dec.inst = inst_XOR;
          {7'h00, 3'd5}: dec.inst = inst_SRL;
          {7'h20, 3'd5}: dec.inst = inst_SRA;
          {7'h00, 3'd6}: dec.inst = inst_OR;
          {7'h00, 3'd7}: dec.inst = inst_AND;
          default: ;
        endcase
      end
      OP_IMM: begin
        dec.imm = imm_i;
        case (f3)
          3'd0: dec.inst = inst_ADDI;
          3'd2: dec.inst = inst_SLTI;
          3'd3: dec.inst = inst_SLTIU;
          3'd4: dec.inst = inst_XORI;
          3'd6: dec.inst = inst_ORI;
          3'd7: dec.inst = inst_ANDI;
          3'd1: begin
            dec.imm = imm_sh;
            if (f7 == 7'h00) dec.inst = inst_SLLI;
          end
          default: begin
            dec.imm = imm_sh;
            if (f7 == 7'h00)      dec.inst = inst_SRLI;
            else if (f7 == 7'h20) dec.inst = inst_SRAI;
          end
        endcase
      end
      LOAD: begin
        dec.imm = imm_i;
        case (f3)
          3'd0: dec.inst = inst_LB;
          3'd1: dec.inst = inst_LH;
          3'd2: dec.inst = inst_LW;
          3'd4: dec.inst = inst_LBU;
          3'd5: dec.inst = inst_LHU;
          default: ;
        endcase
      end
      STORE: begin
        dec.imm = imm_s;
        case (f3)
          3'd0: dec.inst = inst_SB;
          3'd1: dec.inst = inst_SH;
          3'd2: dec.inst = inst_SW;
          default: ;
        endcase
      end
      BRANCH: begin
        dec.imm = imm_b;
        case (f3)
          3'd0: dec.inst = inst_BEQ;
          3'd1: dec.inst = inst_BNE;
          3'd4: dec.inst = inst_BLT;
          3'd5: dec.inst = inst_BGE;
          3'd6: dec.inst = inst_BLTU;
          3'd7: dec.inst = inst_BGEU;
          default: ;
        endcase
      end
      JAL:   begin dec.imm = imm_j; dec.inst = inst_JAL; end
      JALR:  begin dec.imm = imm_i; if (f3 == 3'd0) dec.inst = inst_JALR; end
      LUI:   begin dec.imm = imm_u; dec.inst = inst_LUI; end
      AUIPC: begin dec.imm = imm_u; dec.inst = inst_AUIPC; end
      SYSTEM: begin
        dec.imm = imm_csr;
        case (f3)
          3'd0: begin
            dec.imm = imm_i;
            if (instruction == 32'h0000_0073)      dec.inst = inst_ECALL;
            else if (instruction == 32'h0010_0073) dec.inst = inst_EBREAK;
          end
          3'd1: dec.inst = inst_CSRRW;
          3'd2: dec.inst = inst_CSRRS;
          3'd3: dec.inst = inst_CSRRC;
          3'd5: dec.inst = inst_CSRRWI;
          3'd6: dec.inst = inst_CSRRSI;
          3'd7: dec.inst = inst_CSRRCI;
          default: ;
        endcase
      end
      MISC_MEM: begin
        dec.imm = imm_i;
        if (f3 == 3'd0)      dec.inst = inst_FENCE;
        else if (f3 == 3'd1) dec.inst = inst_FENCEI;
      end
      default: ;
    endcase
    // Unrecognised encodings carry no immediate so o_imm cannot leak a bogus value.
    if (dec.inst == inst_UNKNOWN) dec.imm = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: registered output slot plus one skid entry so that
// o_inst_ready is driven from a flop rather than from i_ready.
module decode_stage
  import riscv_inst_pkg::*;
#(
  parameter int N_param = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_inst_valid,
  output logic               o_inst_ready,
  input  logic [N_param-1:0] i_instruction,
  input  logic [N_param-1:0] i_pc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [63:0]        o_Single_Instruction,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_rs1,
  output logic [4:0]         o_rs2,
  output logic [2:0]         o_fun3,
  output logic [6:0]         o_fun7,
  output logic [N_param-1:0] o_imm,
  output logic [N_param-1:0] o_pc,
  output logic               o_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0] state_p1, state_nxt;
  logic       rdy_p1, vld_p1, accept, consume;
  dec_t       dec_p0;
  slot_t      in_p0, out_p1, skid_p1;

  // ---- p0: combinational decode of the offered word
  rv32i_inst_decoder u_dec (
    .instruction (i_instruction),
    .dec         (dec_p0)
  );

  assign in_p0   = {dec_p0, i_pc};
  assign vld_p1  = (state_p1 != ST_EMPTY);
  assign accept  = i_inst_valid & rdy_p1;
  assign consume = vld_p1 & i_ready;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !consume)      state_nxt = ST_FULL;
        else if (consume && !accept) state_nxt = ST_EMPTY;
      end
      ST_FULL: if (consume) state_nxt = ST_ONE;
      default: state_nxt = ST_EMPTY;
    endcase
    if (i_flush) state_nxt = ST_EMPTY;
  end

  // ---- p1: output slot and skid entry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_p1 <= ST_EMPTY;
      rdy_p1   <= 1'b0;
      out_p1   <= '0;
      skid_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      rdy_p1   <= (state_nxt != ST_FULL);
      if (!i_flush) begin
        case (state_p1)
          ST_EMPTY: if (accept) out_p1 <= in_p0;
          ST_ONE: begin
            if (accept && consume) out_p1  <= in_p0;
            else if (accept)       skid_p1 <= in_p0;
          end
          ST_FULL: if (consume) out_p1 <= skid_p1;
          default: ;
        endcase
      end
    end
  end

  assign o_inst_ready         = rdy_p1;
  assign o_valid              = vld_p1;
  assign o_Single_Instruction = out_p1.dec.inst;
  assign o_rd                 = out_p1.dec.rd;
  assign o_rs1                = out_p1.dec.rs1;
  assign o_rs2                = out_p1.dec.rs2;
  assign o_fun3               = out_p1.dec.fun3;
  assign o_fun7               = out_p1.dec.fun7;
  assign o_imm                = out_p1.dec.imm;
  assign o_pc                 = out_p1.pc;
  assign o_illegal            = out_p1.dec.inst[0];

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction words with
// hand-decoded expectations, backpressure, flush and mid-stream reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, rdy;
  logic [31:0] instr, pc;
  logic        o_inst_ready, o_valid, o_illegal;
  logic [63:0] o_inst;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_fun3;
  logic [6:0]  o_fun7;
  logic [31:0] o_imm, o_pc;

  always #5 clk = ~clk;

  decode_stage #(.N_param(32)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_flush              (flush),
    .i_inst_valid         (in_valid),
    .o_inst_ready         (o_inst_ready),
    .i_instruction        (instr),
    .i_pc                 (pc),
    .o_valid              (o_valid),
    .i_ready              (rdy),
    .o_Single_Instruction (o_inst),
    .o_rd                 (o_rd),
    .o_rs1                (o_rs1),
    .o_rs2                (o_rs2),
    .o_fun3               (o_fun3),
    .o_fun7               (o_fun7),
    .o_imm                (o_imm),
    .o_pc                 (o_pc),
    .o_illegal            (o_illegal)
  );

  typedef struct {
    logic [31:0] word;
    int          idx;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [63:0] inst;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, pc;
    logic        ill;
  } exp_t;

  vec_t  vec [13];
  exp_t  cur_exp;
  exp_t  sb [$];
  int    rd_ptr = 0;
  int    n_vec = 0, n_err = 0;
  int    ctl_req = 0, ctl_ack = 0;
  logic  c_valid, c_ready, c_zero, c_empty;
  string c_name;

  function automatic vec_t mk(input logic [31:0] w, input int idx, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    vec_t v;
    v.word = w; v.idx = idx; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected-response feeder: records every accepted word, forgets on flush/reset.
  always @(negedge clk) begin
    if (rst_n && !flush && in_valid && o_inst_ready === 1'b1) sb.push_back(cur_exp);
  end

  // Output monitor: compares each consumed output and services control checks.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      rd_ptr = sb.size();
    end else if (o_valid === 1'b1 && rdy) begin
      chk("sb_pending", 64'(rd_ptr < sb.size()), 64'd1);
      if (rd_ptr < sb.size()) begin
        e = sb[rd_ptr];
        rd_ptr++;
        chk("o_Single_Instruction", o_inst, e.inst);
        chk("o_rd", 64'(o_rd), 64'(e.rd));
        chk("o_rs1", 64'(o_rs1), 64'(e.rs1));
        chk("o_rs2", 64'(o_rs2), 64'(e.rs2));
        chk("o_fun3", 64'(o_fun3), 64'(e.f3));
        chk("o_fun7", 64'(o_fun7), 64'(e.f7));
        chk("o_imm", 64'(o_imm), 64'(e.imm));
        chk("o_pc", 64'(o_pc), 64'(e.pc));
        chk("o_illegal", 64'(o_illegal), 64'(e.ill));
      end
    end
    if (ctl_req != ctl_ack) begin
      chk({c_name, ".o_valid"}, 64'(o_valid), 64'(c_valid));
      chk({c_name, ".o_inst_ready"}, 64'(o_inst_ready), 64'(c_ready));
      if (c_zero)
        chk({c_name, ".data_zero"},
            64'(|{o_inst, o_rd, o_rs1, o_rs2, o_fun3, o_fun7, o_imm, o_pc, o_illegal}), 64'd0);
      if (c_empty) chk({c_name, ".sb_outstanding"}, 64'(sb.size() - rd_ptr), 64'd0);
      ctl_ack = ctl_req;
    end
  end

  task automatic post(input string nm, input logic v, input logic r, input logic z, input logic em);
    c_name = nm; c_valid = v; c_ready = r; c_zero = z; c_empty = em;
    ctl_req++;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int k);
    instr        = vec[k].word;
    pc           = 32'h1000 + 32'(k * 4);
    cur_exp.inst = 64'd1 << vec[k].idx;
    cur_exp.rd   = vec[k].rd;
    cur_exp.rs1  = vec[k].rs1;
    cur_exp.rs2  = vec[k].rs2;
    cur_exp.f3   = vec[k].f3;
    cur_exp.f7   = vec[k].f7;
    cur_exp.imm  = vec[k].imm;
    cur_exp.pc   = pc;
    cur_exp.ill  = (vec[k].idx == 0);
    in_valid     = 1'b1;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = (o_inst_ready === 1'b1) && rst_n && !flush;
      @(posedge clk); #1;
    end
    if (!acc) begin
      $display("FAIL handshake: o_inst_ready stayed %b, required 1", o_inst_ready);
      $fatal(1, "accept timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input int k);
    drive(k);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = mk(32'h002081B3,  1, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h0000_0000); // ADD
    vec[1]  = mk(32'hFE000EE3, 28, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFF_FFFC); // BEQ -4
    vec[2]  = mk(32'h0020A423, 27, 5'd8,  5'd1, 5'd2,  3'd2, 7'h00, 32'h0000_0008); // SW
    vec[3]  = mk(32'h123452B7, 36, 5'd5,  5'd8, 5'd3,  3'd5, 7'h09, 32'h1234_5000); // LUI
    vec[4]  = mk(32'h00000000,  0, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0000); // zero word
    vec[5]  = mk(32'hFFF00093, 11, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF); // ADDI -1
    vec[6]  = mk(32'h40335293, 17, 5'd5,  5'd6, 5'd3,  3'd5, 7'h20, 32'h0000_0003); // SRAI
    vec[7]  = mk(32'h02331293,  0, 5'd5,  5'd6, 5'd3,  3'd1, 7'h01, 32'h0000_0000); // SLLI bit25
    vec[8]  = mk(32'h008000EF, 34, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00, 32'h0000_0008); // JAL +8
    vec[9]  = mk(32'h305110F3, 42, 5'd1,  5'd2, 5'd5,  3'd1, 7'h18, 32'h0000_0305); // CSRRW
    vec[10] = mk(32'h00000073, 38, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0000); // ECALL
    vec[11] = mk(32'hFFC12383, 22, 5'd7,  5'd2, 5'd28, 3'd2, 7'h7F, 32'hFFFF_FFFC); // LW -4
    vec[12] = mk(32'h402081B3,  2, 5'd3,  5'd1, 5'd2,  3'd0, 7'h20, 32'h0000_0000); // SUB

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; rdy = 1'b0;
    instr = '0; pc = '0; cur_exp = '{default: '0};
    c_valid = 1'b0; c_ready = 1'b0; c_zero = 1'b0; c_empty = 1'b0; c_name = "";

    repeat (2) @(posedge clk);
    #1;
    post("in_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(1);
    post("after_reset", 1'b0, 1'b1, 1'b1, 1'b0);

    // Streaming with execute always ready.
    rdy = 1'b1;
    for (int k = 0; k < 9; k++) send(k);
    idle(2);

    // Backpressure: two words fill slot + skid, third waits.
    rdy = 1'b0;
    send(9);
    send(10);
    post("bp_full", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(11);
    idle(3);
    rdy = 1'b1;
    wait_accept();
    idle(3);

    // Flush while FULL with a word offered.
    rdy = 1'b0;
    send(12);
    send(0);
    drive(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    post("flush_full", 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush in ONE while an accept would otherwise happen.
    send(3);
    drive(4);
    flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    post("flush_one", 1'b0, 1'b1, 1'b0, 1'b0);

    rdy = 1'b1;
    for (int k = 5; k < 8; k++) send(k);
    idle(2);

    // Reset while FULL, then resume.
    rdy = 1'b0;
    send(8);
    send(9);
    rst_n = 1'b0;
    idle(1);
    post("reset_mid", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle(1);
    post("reset_release", 1'b0, 1'b1, 1'b1, 1'b0);

    rdy = 1'b1;
    for (int k = 10; k < 13; k++) send(k);
    idle(4);
    post("drain", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
